// File: rtl/regfile_write_buffer_pkg.sv
// rtl/regfile_write_buffer_pkg.sv - shared widths, zero-register constant and entry type
//   WB_DATA_W  : default register data width
//   WB_ADDR_W  : default register address width
//   REG_ZERO   : hard-wired zero register address; writes to it are dropped
//   wb_entry_t : one pending write {addr, data}
package regfile_write_buffer_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;

  localparam logic [WB_ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_write_buffer_bypass_match.sv
// rtl/regfile_write_buffer_bypass_match.sv - youngest-match lookup over the pending-write array
//   entries : pending-write storage
//   valid   : per-slot occupancy mask
//   wr_ptr  : next slot to be written (the slot just before it is the youngest)
//   addr    : lookup register address
//   hit     : a valid entry targets addr (never for the zero register)
//   data    : data of the youngest matching entry, 0 when no hit
module regfile_bypass_match
  import regfile_write_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  wb_entry_t              entries [DEPTH],
  input  logic [DEPTH-1:0]       valid,
  input  logic [PTR_W-1:0]       wr_ptr,
  input  logic [WB_ADDR_W-1:0]   addr,
  output logic                   hit,
  output logic [WB_DATA_W-1:0]   data
);

  logic [PTR_W-1:0] idx;

  // Walk from oldest (wr_ptr - DEPTH) to youngest (wr_ptr - 1) so the last
  // match seen wins. PTR_W'(DEPTH) wraps to 0, which is the oldest slot.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int i = DEPTH; i >= 1; i--) begin
      idx = wr_ptr - PTR_W'(i);
      if (valid[idx] && (entries[idx].addr == addr) && (addr != REG_ZERO)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/regfile_write_buffer.sv
// rtl/regfile_write_buffer.sv - in-order write-back FIFO in front of the register file write port
//   Optional feature macro: WB_COALESCE_EN (push to a pending address overwrites it in place)
//   CLOCK, RESET_N             : clock, synchronous active-low reset
//   IN_VALID/IN_READY/IN_A/IN_D: write request handshake, address, data
//   DRAIN_EN                   : write port free this cycle
//   A3/WD/WE                   : register file write port (head entry)
//   Q1_A/Q1_HIT/Q1_D           : operand 1 bypass lookup
//   Q2_A/Q2_HIT/Q2_D           : operand 2 bypass lookup
//   EMPTY                      : no pending entries
module regfile_write_buffer
  import regfile_write_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [ADDR_W-1:0] IN_A,
  input  logic [DATA_W-1:0] IN_D,
  input  logic              DRAIN_EN,
  output logic [ADDR_W-1:0] A3,
  output logic [DATA_W-1:0] WD,
  output logic              WE,
  input  logic [ADDR_W-1:0] Q1_A,
  output logic              Q1_HIT,
  output logic [DATA_W-1:0] Q1_D,
  input  logic [ADDR_W-1:0] Q2_A,
  output logic              Q2_HIT,
  output logic [DATA_W-1:0] Q2_D,
  output logic              EMPTY
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t          mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count;
  logic [DEPTH-1:0]   valid;
  logic               accept;
  logic               alloc;
  logic               coal_hit;

  assign EMPTY    = (count == '0);
  assign IN_READY = (count != (PTR_W+1)'(DEPTH));
  // Gated by RESET_N so a reset arriving mid-drain never commits the head.
  assign WE       = RESET_N && !EMPTY && DRAIN_EN;
  assign A3       = EMPTY ? '0 : mem[rd_ptr].addr;
  assign WD       = EMPTY ? '0 : mem[rd_ptr].data;

  // Requests to the zero register are acknowledged but never stored.
  assign accept   = IN_VALID && IN_READY && (IN_A != REG_ZERO);
  assign alloc    = accept && !coal_hit;

  // Slot j is occupied when its distance from the head is below count.
  always_comb begin
    valid = '0;
    for (int j = 0; j < DEPTH; j++) begin
      valid[j] = ({1'b0, PTR_W'(j) - rd_ptr} < count);
    end
  end

`ifdef WB_COALESCE_EN
  logic [PTR_W-1:0] coal_idx;

  // At most one entry per address exists. The head leaving this cycle is
  // excluded so the new value gets its own slot instead of being lost.
  always_comb begin
    coal_hit = 1'b0;
    coal_idx = '0;
    for (int j = 0; j < DEPTH; j++) begin
      if (valid[j] && (mem[j].addr == IN_A) && !(WE && (PTR_W'(j) == rd_ptr))) begin
        coal_hit = 1'b1;
        coal_idx = PTR_W'(j);
      end
    end
  end
`else
  assign coal_hit = 1'b0;
`endif

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (alloc) wr_ptr <= wr_ptr + PTR_W'(1);
      if (WE)    rd_ptr <= rd_ptr + PTR_W'(1);
      case ({alloc, WE})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry payload carries no reset; occupancy is defined by the pointers.
  always_ff @(posedge CLOCK) begin
    if (alloc) begin
      mem[wr_ptr] <= '{addr: IN_A, data: IN_D};
    end
`ifdef WB_COALESCE_EN
    else if (accept && coal_hit) begin
      mem[coal_idx].data <= IN_D;
    end
`endif
  end

  regfile_bypass_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_match_q1 (
    .entries (mem),
    .valid   (valid),
    .wr_ptr  (wr_ptr),
    .addr    (Q1_A),
    .hit     (Q1_HIT),
    .data    (Q1_D)
  );

  regfile_bypass_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_match_q2 (
    .entries (mem),
    .valid   (valid),
    .wr_ptr  (wr_ptr),
    .addr    (Q2_A),
    .hit     (Q2_HIT),
    .data    (Q2_D)
  );

endmodule

// File: tb/tb_regfile_write_buffer.sv
// tb/tb_regfile_write_buffer.sv - scoreboard bench for regfile_write_buffer
module tb_regfile_write_buffer;

  localparam int DEPTH = 4;

  logic        CLOCK    = 1'b0;
  logic        RESET_N  = 1'b0;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [4:0]  IN_A     = '0;
  logic [31:0] IN_D     = '0;
  logic        DRAIN_EN = 1'b0;
  logic [4:0]  A3;
  logic [31:0] WD;
  logic        WE;
  logic [4:0]  Q1_A     = '0;
  logic        Q1_HIT;
  logic [31:0] Q1_D;
  logic [4:0]  Q2_A     = '0;
  logic        Q2_HIT;
  logic [31:0] Q2_D;
  logic        EMPTY;

  regfile_write_buffer #(.DEPTH(DEPTH)) dut (
    .CLOCK    (CLOCK),
    .RESET_N  (RESET_N),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .IN_A     (IN_A),
    .IN_D     (IN_D),
    .DRAIN_EN (DRAIN_EN),
    .A3       (A3),
    .WD       (WD),
    .WE       (WE),
    .Q1_A     (Q1_A),
    .Q1_HIT   (Q1_HIT),
    .Q1_D     (Q1_D),
    .Q2_A     (Q2_A),
    .Q2_HIT   (Q2_HIT),
    .Q2_D     (Q2_D),
    .EMPTY    (EMPTY)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  // Pending writes in push order; front is the next expected commit.
  ent_t q[$];
  int   errors  = 0;
  int   checks  = 0;
  bit   started = 0;
  bit   popped  = 0;
  bit   exp_we;
  bit   mh;
  logic [31:0] md;
  int   pre;
  bit   coalesced;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void lookup(input logic [4:0] a, output bit h, output logic [31:0] d);
    h = 0;
    d = '0;
    if (a != 5'd0) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].a == a) begin
          h = 1;
          d = q[i].d;
          break;
        end
      end
    end
  endfunction

  // Reference model: applies accepted pushes at the clock edge.
  always @(posedge CLOCK) begin
    if (!RESET_N) begin
      q.delete();
      started = 1;
    end else if (started) begin
      pre = q.size() + (popped ? 1 : 0);
      if (IN_VALID && (pre != DEPTH) && (IN_A != 5'd0)) begin
        coalesced = 0;
`ifdef WB_COALESCE_EN
        foreach (q[i]) begin
          if (q[i].a == IN_A) begin
            q[i].d    = IN_D;
            coalesced = 1;
          end
        end
`endif
        if (!coalesced) q.push_back('{a: IN_A, d: IN_D});
      end
    end
  end

  // Monitor: compares DUT outputs mid-cycle and retires commits.
  always @(negedge CLOCK) begin
    popped = 0;
    if (started) begin
      exp_we = RESET_N && (q.size() != 0) && DRAIN_EN;
      chk("empty", EMPTY, q.size() == 0);
      chk("in_ready", IN_READY, q.size() != DEPTH);
      chk("we", WE, exp_we);
      lookup(Q1_A, mh, md);
      chk("q1_hit", Q1_HIT, mh);
      chk("q1_d", Q1_D, md);
      lookup(Q2_A, mh, md);
      chk("q2_hit", Q2_HIT, mh);
      chk("q2_d", Q2_D, md);
      if (q.size() == 0) begin
        chk("a3_idle", A3, 0);
        chk("wd_idle", WD, 0);
      end else begin
        chk("a3", A3, q[0].a);
        chk("wd", WD, q[0].d);
      end
      if (WE === 1'b1) begin
        if (q.size() == 0) begin
          chk("commit_unexpected", 1, 0);
        end else begin
          void'(q.pop_front());
          popped = 1;
        end
      end
    end
  end

  task automatic step(input bit v, input logic [4:0] a, input logic [31:0] d, input bit dr);
    IN_VALID = v;
    IN_A     = a;
    IN_D     = d;
    DRAIN_EN = dr;
    @(posedge CLOCK);
    #1;
  endtask

  task automatic idle(input int n, input bit dr);
    for (int i = 0; i < n; i++) step(0, 5'd0, 32'd0, dr);
  endtask

  initial begin
    // Reset held two cycles with a request present.
    IN_VALID = 1'b1;
    IN_A     = 5'd3;
    IN_D     = 32'h5;
    repeat (2) @(posedge CLOCK);
    #1;
    RESET_N = 1'b1;
    idle(1, 0);

    // Fill to full, fifth push refused, then drain in order.
    Q1_A = 5'd3;
    Q2_A = 5'd5;
    step(1, 5'd1, 32'h11, 0);
    step(1, 5'd2, 32'h22, 0);
    step(1, 5'd3, 32'h33, 0);
    step(1, 5'd4, 32'h44, 0);
    step(1, 5'd5, 32'h55, 0);
    idle(6, 1);

    // Register zero is dropped.
    Q1_A = 5'd0;
    step(1, 5'd0, 32'hDEAD, 1);
    idle(2, 1);

    // Two writes to r7: bypass shows the younger, commits oldest first.
    Q1_A = 5'd7;
    step(1, 5'd7, 32'hA, 0);
    step(1, 5'd7, 32'hB, 0);
    idle(1, 0);
    idle(3, 1);

    // Push while popping at two pending entries.
    Q2_A = 5'd9;
    step(1, 5'd8, 32'h88, 0);
    step(1, 5'd10, 32'h10, 0);
    step(1, 5'd9, 32'h99, 1);
    idle(4, 1);

    // Same address twice; coalesced builds commit it once.
    Q1_A = 5'd5;
    step(1, 5'd5, 32'h1, 0);
    step(1, 5'd5, 32'h2, 0);
    idle(3, 1);

    // Reset mid-drain discards pending entries.
    step(1, 5'd6, 32'h66, 0);
    step(1, 5'd11, 32'h77, 0);
    step(1, 5'd12, 32'h88, 1);
    RESET_N = 1'b0;
    step(0, 5'd0, 32'd0, 1);
    RESET_N = 1'b1;
    idle(2, 1);

    // Randomized traffic over a small address range to force collisions.
    for (int n = 0; n < 2000; n++) begin
      Q1_A    = 5'($urandom_range(0, 7));
      Q2_A    = 5'($urandom_range(0, 7));
      RESET_N = ($urandom_range(0, 199) != 0);
      step(bit'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 2) == 0));
    end
    RESET_N = 1'b1;
    idle(DEPTH + 2, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
